// File: rtl/ysyx_25050147_lsu_pkg.sv
// ysyx_25050147_lsu_pkg: funct3 codes, access sizes and FSM states shared by the LSU
package ysyx_25050147_lsu_pkg;
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} lsu_state_e;
endpackage

// File: rtl/ysyx_25050147_lsu_align.sv
// ysyx_25050147_lsu_align: legality check, store replication/strobes, load lane extract and extend
module ysyx_25050147_lsu_align
    import ysyx_25050147_lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NBYTES = XLEN / 8,
    localparam int OW = $clog2(NBYTES)
) (
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [OW-1:0]     off,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic              ok,
    output logic [NBYTES-1:0] wstrb,
    output logic [XLEN-1:0]   wdata_rep,
    output logic [XLEN-1:0]   ext
);
    logic [1:0] size;
    logic [2:0] off3;
    logic [6:0] nbits;
    logic [7:0] bmask;
    logic [XLEN-1:0] lane, mask;
    logic msb;
    always_comb begin
        size = funct3[1:0];
        off3 = 3'(off);
        ok = !((XLEN == 32 && size == SZ_D) || funct3 == 3'b111 || (we && funct3[2]))
             && (off3 & ((3'b1 << size) - 3'b1)) == 3'b0;
        bmask = size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0f : 8'hff;
        wstrb = we ? NBYTES'(bmask) << off : '0;
        wdata_rep = size == SZ_B ? {NBYTES{wdata[7:0]}} :
                    size == SZ_H ? {(NBYTES/2){wdata[15:0]}} :
                    size == SZ_W ? {(NBYTES/4){wdata[31:0]}} : wdata;
        lane = rdata >> {off, 3'b000};
        nbits = 7'd8 << size;
        mask = ~({XLEN{1'b1}} << nbits);
        msb = ~funct3[2] & |(lane & mask & ~(mask >> 1));
        ext = (lane & mask) | ({XLEN{msb}} & ~mask);
    end
endmodule

// File: rtl/ysyx_25050147_lsu.sv
// ysyx_25050147_lsu: single-outstanding load/store unit between the execute stage and the data bus
module ysyx_25050147_lsu
    import ysyx_25050147_lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ADDR_W = 32,
    localparam int NBYTES = XLEN / 8,
    localparam int OW = $clog2(NBYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [NBYTES-1:0] mem_req_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata,
    input  logic              mem_rsp_err
);
    lsu_state_e state;
    logic cap_we, idle, a_we, ok;
    logic [2:0] cap_funct3, a_funct3;
    logic [ADDR_W-1:0] cap_addr;
    logic [OW-1:0] a_off;
    logic [NBYTES-1:0] strb;
    logic [XLEN-1:0] rep, ext;
    assign idle = state == S_IDLE;
    assign req_ready = idle;
    assign mem_req_valid = state == S_REQ;
    assign rsp_valid = state == S_RESP;
    assign mem_req_we = cap_we;
    assign mem_req_addr = {cap_addr[ADDR_W-1:OW], {OW{1'b0}}};
    // The checker sees the live request while idle and the captured one afterwards.
    assign a_we = idle ? req_we : cap_we;
    assign a_funct3 = idle ? req_funct3 : cap_funct3;
    assign a_off = idle ? req_addr[OW-1:0] : cap_addr[OW-1:0];
    ysyx_25050147_lsu_align #(.XLEN(XLEN)) u_align (
        .we(a_we),
        .funct3(a_funct3),
        .off(a_off),
        .wdata(req_wdata),
        .rdata(mem_rsp_rdata),
        .ok(ok),
        .wstrb(strb),
        .wdata_rep(rep),
        .ext(ext)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cap_we <= 1'b0;
            cap_funct3 <= '0;
            cap_addr <= '0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
            rsp_rdata <= '0;
            rsp_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    cap_we <= req_we;
                    cap_funct3 <= req_funct3;
                    cap_addr <= req_addr;
                    mem_req_wdata <= rep;
                    mem_req_wstrb <= strb;
                    rsp_rdata <= '0;
                    rsp_err <= ~ok;
                    state <= ok ? S_REQ : S_RESP;
                end
                S_REQ: if (mem_req_ready) state <= S_WAIT;
                S_WAIT: if (mem_rsp_valid) begin
                    rsp_err <= mem_rsp_err;
                    rsp_rdata <= (!cap_we && !mem_rsp_err) ? ext : '0;
                    state <= S_RESP;
                end
                S_RESP: if (rsp_ready) state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_25050147_lsu.sv
// tb_ysyx_25050147_lsu: table-driven scoreboard bench over XLEN=32 and XLEN=64 instances
module tb_ysyx_25050147_lsu;
    import ysyx_25050147_lsu_pkg::*;
    typedef struct {
        logic x64; logic we; logic [2:0] f3; logic [31:0] addr; logic [63:0] wdata;
        logic [63:0] brd; logic berr;
        logic bus; logic [31:0] maddr; logic [63:0] ewd; logic [7:0] estrb; logic [63:0] erd; logic eerr;
    } vec_t;
    typedef struct { logic [63:0] rdata; logic err; } exp_t;
    logic clk = 0, rst, sel;
    logic req_valid, req_we, rsp_ready, mem_req_ready, mem_rsp_valid, mem_rsp_err;
    logic [2:0] req_funct3;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, mem_rsp_rdata;
    logic a_req_ready, a_rsp_valid, a_rsp_err, a_mvalid, a_mwe;
    logic [31:0] a_rsp_rdata, a_maddr, a_mwdata;
    logic [3:0] a_mwstrb;
    logic b_req_ready, b_rsp_valid, b_rsp_err, b_mvalid, b_mwe;
    logic [63:0] b_rsp_rdata, b_mwdata;
    logic [31:0] b_maddr;
    logic [7:0] b_mwstrb;
    logic o_req_ready, o_rsp_valid, o_rsp_err, o_mvalid, o_mwe;
    logic [63:0] o_rsp_rdata, o_mwdata;
    logic [31:0] o_maddr;
    logic [7:0] o_mwstrb;
    int n_cmp = 0, n_bad = 0, hs_cnt = 0, mv_cnt = 0;
    vec_t vt[$];
    exp_t sb[$];
    always #5 clk = ~clk;
    ysyx_25050147_lsu #(.XLEN(32)) d32 (
        .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .mem_req_valid(a_mvalid), .mem_req_ready(mem_req_ready), .mem_req_we(a_mwe),
        .mem_req_addr(a_maddr), .mem_req_wdata(a_mwdata), .mem_req_wstrb(a_mwstrb),
        .mem_rsp_valid(mem_rsp_valid & ~sel), .mem_rsp_rdata(mem_rsp_rdata[31:0]), .mem_rsp_err(mem_rsp_err)
    );
    ysyx_25050147_lsu #(.XLEN(64)) d64 (
        .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(b_req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .mem_req_valid(b_mvalid), .mem_req_ready(mem_req_ready), .mem_req_we(b_mwe),
        .mem_req_addr(b_maddr), .mem_req_wdata(b_mwdata), .mem_req_wstrb(b_mwstrb),
        .mem_rsp_valid(mem_rsp_valid & sel), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err)
    );
    assign o_req_ready = sel ? b_req_ready : a_req_ready;
    assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign o_rsp_err = sel ? b_rsp_err : a_rsp_err;
    assign o_rsp_rdata = sel ? b_rsp_rdata : 64'(a_rsp_rdata);
    assign o_mvalid = sel ? b_mvalid : a_mvalid;
    assign o_mwe = sel ? b_mwe : a_mwe;
    assign o_maddr = sel ? b_maddr : a_maddr;
    assign o_mwdata = sel ? b_mwdata : 64'(a_mwdata);
    assign o_mwstrb = sel ? b_mwstrb : 8'(a_mwstrb);
    always @(posedge clk) begin
        if (o_mvalid && mem_req_ready) hs_cnt <= hs_cnt + 1;
        if (o_mvalid) mv_cnt <= mv_cnt + 1;
    end
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, got, want);
        end
    endtask
    function automatic vec_t mk(input logic x64, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [63:0] wdata, input logic [63:0] brd, input logic berr,
                                input logic bus, input logic [31:0] maddr, input logic [63:0] ewd,
                                input logic [7:0] estrb, input logic [63:0] erd, input logic eerr);
        vec_t v;
        v.x64 = x64; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.brd = brd; v.berr = berr;
        v.bus = bus; v.maddr = maddr; v.ewd = ewd; v.estrb = estrb; v.erd = erd; v.eerr = eerr;
        return v;
    endfunction
    task automatic reset_chk(input string tag);
        chk({tag, "_req_ready"}, 64'(o_req_ready), 64'd1);
        chk({tag, "_rsp_valid"}, 64'(o_rsp_valid), 64'd0);
        chk({tag, "_rsp_err"}, 64'(o_rsp_err), 64'd0);
        chk({tag, "_rsp_rdata"}, o_rsp_rdata, 64'd0);
        chk({tag, "_mem_req_valid"}, 64'(o_mvalid), 64'd0);
        chk({tag, "_mem_req_we"}, 64'(o_mwe), 64'd0);
        chk({tag, "_mem_req_wstrb"}, 64'(o_mwstrb), 64'd0);
    endtask
    task automatic txn(input vec_t v, input int rs, input int ps);
        exp_t e;
        int hs0, mv0;
        sel = v.x64;
        @(negedge clk);
        chk("req_ready_idle", 64'(o_req_ready), 64'd1);
        req_valid = 1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        sb.push_back('{v.erd, v.eerr});
        hs0 = hs_cnt; mv0 = mv_cnt;
        @(negedge clk);
        req_valid = 0;
        chk("req_ready_busy", 64'(o_req_ready), 64'd0);
        if (v.bus) begin
            for (int i = 0; i <= rs; i++) begin
                if (i > 0) @(negedge clk);
                chk("mem_req_valid", 64'(o_mvalid), 64'd1);
                chk("mem_req_we", 64'(o_mwe), 64'(v.we));
                chk("mem_req_addr", 64'(o_maddr), 64'(v.maddr));
                chk("mem_req_wdata", o_mwdata, v.ewd);
                chk("mem_req_wstrb", 64'(o_mwstrb), 64'(v.estrb));
                chk("req_ready_req", 64'(o_req_ready), 64'd0);
            end
            mem_req_ready = 1;
            @(negedge clk);
            mem_req_ready = 0;
            chk("mem_req_drop", 64'(o_mvalid), 64'd0);
            chk("rsp_early", 64'(o_rsp_valid), 64'd0);
            mem_rsp_valid = 1; mem_rsp_rdata = v.brd; mem_rsp_err = v.berr;
            @(negedge clk);
            mem_rsp_valid = 0; mem_rsp_err = 0;
        end
        chk("rsp_valid", 64'(o_rsp_valid), 64'd1);
        chk("bus_handshakes", 64'(hs_cnt - hs0), v.bus ? 64'd1 : 64'd0);
        chk("mem_req_cycles", 64'(mv_cnt - mv0), v.bus ? 64'(rs + 1) : 64'd0);
        e = sb.pop_front();
        for (int i = 0; i <= ps; i++) begin
            if (i > 0) @(negedge clk);
            chk("rsp_valid_hold", 64'(o_rsp_valid), 64'd1);
            chk("rsp_rdata", o_rsp_rdata, e.rdata);
            chk("rsp_err", 64'(o_rsp_err), 64'(e.err));
            chk("req_ready_resp", 64'(o_req_ready), 64'd0);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("rsp_done", 64'(o_rsp_valid), 64'd0);
        chk("req_ready_back", 64'(o_req_ready), 64'd1);
    endtask
    initial begin
        rst = 1; sel = 0; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        rsp_ready = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0; mem_rsp_err = 0;
        vt.push_back(mk(0, 0, LB,  32'h8000_0003, 0, 64'h80FF_1234, 0, 1, 32'h8000_0000, 0, 8'h0, 64'hFFFF_FF80, 0));
        vt.push_back(mk(0, 0, LBU, 32'h8000_0003, 0, 64'h80FF_1234, 0, 1, 32'h8000_0000, 0, 8'h0, 64'h0000_0080, 0));
        vt.push_back(mk(0, 0, LHU, 32'h8000_0002, 0, 64'h80FF_1234, 0, 1, 32'h8000_0000, 0, 8'h0, 64'h0000_80FF, 0));
        vt.push_back(mk(0, 1, SH,  32'h8000_0002, 64'h1234_ABCD, 64'hDEAD_BEEF, 0, 1, 32'h8000_0000, 64'hABCD_ABCD, 8'hC, 0, 0));
        vt.push_back(mk(0, 0, LW,  32'h8000_0002, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, LD,  32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, LW,  32'h8000_0004, 0, 64'h1234_5678, 1, 1, 32'h8000_0004, 0, 8'h0, 0, 1));
        vt.push_back(mk(1, 0, LW,  32'h8000_0004, 0, 64'h8000_0001_0000_0000, 0, 1, 32'h8000_0000, 0, 8'h0, 64'hFFFF_FFFF_8000_0001, 0));
        vt.push_back(mk(1, 0, LWU, 32'h8000_0004, 0, 64'h8000_0001_0000_0000, 0, 1, 32'h8000_0000, 0, 8'h0, 64'h0000_0000_8000_0001, 0));
        vt.push_back(mk(0, 1, SB,  32'h8000_0001, 64'h0000_00EF, 0, 0, 1, 32'h8000_0000, 64'hEFEF_EFEF, 8'h2, 0, 0));
        vt.push_back(mk(0, 1, SW,  32'h8000_0000, 64'h1122_3344, 0, 0, 1, 32'h8000_0000, 64'h1122_3344, 8'hF, 0, 0));
        vt.push_back(mk(1, 1, SD,  32'h8000_0008, 64'h0102_0304_0506_0708, 0, 0, 1, 32'h8000_0008, 64'h0102_0304_0506_0708, 8'hFF, 0, 0));
        vt.push_back(mk(1, 0, LD,  32'h8000_0000, 0, 64'hFEDC_BA98_7654_3210, 0, 1, 32'h8000_0000, 0, 8'h0, 64'hFEDC_BA98_7654_3210, 0));
        vt.push_back(mk(1, 0, LH,  32'h8000_0006, 0, 64'h8001_0000_0000_0000, 0, 1, 32'h8000_0000, 0, 8'h0, 64'hFFFF_FFFF_FFFF_8001, 0));
        vt.push_back(mk(0, 1, 3'b100, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, 3'b111, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(mk(1, 1, SH,  32'h8000_0006, 64'hBEEF, 0, 0, 1, 32'h8000_0000, 64'hBEEF_BEEF_BEEF_BEEF, 8'hC0, 0, 0));
        vt.push_back(mk(0, 0, LH,  32'h8000_0001, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(mk(1, 0, LD,  32'h8000_0004, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, LB,  32'h8000_0001, 0, 64'h0000_7F00, 0, 1, 32'h8000_0000, 0, 8'h0, 64'h0000_007F, 0));
        vt.push_back(mk(1, 1, SW,  32'h8000_0004, 64'hCAFE_BABE, 0, 0, 1, 32'h8000_0000, 64'hCAFE_BABE_CAFE_BABE, 8'hF0, 0, 0));
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            reset_chk(s == 0 ? "rst32" : "rst64");
        end
        rst = 0;
        foreach (vt[i]) txn(vt[i], 0, 0);
        txn(mk(0, 0, LW, 32'h8000_0008, 0, 64'h1357_2468, 0, 1, 32'h8000_0008, 0, 8'h0, 64'h1357_2468, 0), 3, 2);
        sel = 0;
        @(negedge clk);
        req_valid = 1; req_we = 1; req_funct3 = SW; req_addr = 32'h8000_0010; req_wdata = 64'hA5A5_A5A5;
        @(negedge clk);
        req_valid = 0;
        chk("midrst_mem_req_valid", 64'(o_mvalid), 64'd1);
        mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0;
        chk("midrst_wait_we", 64'(o_mwe), 64'd1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        reset_chk("midrst");
        mem_rsp_valid = 1; mem_rsp_err = 1; mem_rsp_rdata = 64'hFFFF_FFFF;
        @(negedge clk);
        mem_rsp_valid = 0; mem_rsp_err = 0;
        chk("late_rsp_ignored", 64'(o_rsp_valid), 64'd0);
        chk("late_rsp_idle", 64'(o_req_ready), 64'd1);
        txn(mk(0, 0, LW, 32'h8000_0010, 0, 64'h0BAD_F00D, 0, 1, 32'h8000_0010, 0, 8'h0, 64'h0BAD_F00D, 0), 0, 0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ysyx_25050147_lsu.md
Name: ysyx_25050147_lsu

Overview:
Parametrised load/store unit between the NPC execute stage and the data-memory bus. It accepts one load or store per transaction, checks natural alignment, and issues a lane-aligned bus request with write strobes. On loads it extracts the addressed byte, half, word or (XLEN=64) double from the bus word and sign- or zero-extends it to XLEN. Valid/ready handshakes on all sides; single outstanding transaction.

Parameters:
XLEN, 32, data width; 32 or 64 only.
ADDR_W, 32, address width.
NBYTES, XLEN/8, derived bus byte-lanes (localparam, not overridable).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  core request valid.
req_ready  out  1  LSU can accept a request.
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  RISC-V funct3 (size in [1:0]; bit 2 = unsigned for loads).
req_addr  in  ADDR_W  byte address.
req_wdata  in  XLEN  store data, right-justified.
rsp_valid  out  1  result/completion valid.
rsp_ready  in  1  core accepts the response.
rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
rsp_err  out  1  misaligned, illegal size, or bus error.
mem_req_valid  out  1  bus request valid.
mem_req_ready  in  1  bus accepts the request.
mem_req_we  out  1  write enable.
mem_req_addr  out  ADDR_W  req_addr with low log2(NBYTES) bits cleared.
mem_req_wdata  out  XLEN  lane-replicated store data.
mem_req_wstrb  out  NBYTES  byte strobes; 0 for loads.
mem_rsp_valid  in  1  bus response valid; LSU always sinks it in WAIT.
mem_rsp_rdata  in  XLEN  bus read word.
mem_rsp_err  in  1  bus error.

Behaviour:
- The FSM has four states: IDLE, REQ, WAIT and RESP. All outputs are registered or decoded from state.
- Reset, including mid-transaction: state returns to IDLE. req_ready=1. rsp_valid=0, rsp_err=0, rsp_rdata=0. mem_req_valid=0, mem_req_we=0, mem_req_wstrb=0. Captured request fields clear to 0.
- In IDLE, req_ready=1. On req_valid, capture we/funct3/addr/wdata.
  - Legal and aligned: go to REQ.
  - Illegal or misaligned: go to RESP with rsp_err=1 and no bus access.
- Illegal sizes: size=11 when XLEN=32; funct3=111; stores with funct3[2]=1.
- Misaligned: address not a multiple of 2^size.
- In REQ, mem_req_valid=1 and the bus fields are held stable until mem_req_ready. When it arrives, go to WAIT.
- In WAIT, on mem_rsp_valid, go to RESP:
  - Capture rsp_err = mem_rsp_err.
  - For loads with no error, rsp_rdata = extend(lane).
  - Otherwise rsp_rdata = 0.
  - mem_rsp_valid in any other state is ignored.
- In RESP, rsp_valid=1 and rsp_rdata/rsp_err are held until rsp_ready, then go to IDLE. req_ready=0 in every state except IDLE.
- Lane extraction: offset = addr[log2(NBYTES)-1:0]; lane = mem_rsp_rdata >> (8*offset), then truncate to the access size.
- Extension: funct3[2]=0 sign-extends from the lane MSB; funct3[2]=1 zero-extends.
- Stores: wdata low 2^size bytes are replicated across all lanes. wstrb = ((1<<2^size)-1) << offset.
- Latency: request accepted at cycle T. mem_req_valid at T+1. Earliest rsp_valid is T+3 (mem_req_ready at T+1, mem_rsp_valid at T+2). Error path: rsp_valid at T+1.
- Throughput: at most one transaction per 4 cycles; a new request cannot be accepted in the same cycle rsp_ready completes.

Decomposition:
- Shared package ysyx_25050147_lsu_pkg holds:
  - funct3 constants: LB/LH/LW/LD/LBU/LHU/LWU and SB/SH/SW/SD.
  - Size encodings.
  - The LSU state enum.
- One combinational sub-module, ysyx_25050147_lsu_align, holds:
  - Legality and alignment check.
  - wstrb/wdata generation.
  - Load lane extraction and extension.

Test Plan:
- XLEN=32, LB @0x8000_0003, bus rdata 0x80FF_1234 -> rsp_rdata 0xFFFF_FF80, rsp_err=0. Same with LBU -> 0x0000_0080. LHU @0x8000_0002 -> 0x0000_80FF.
- SH @0x8000_0002, wdata 0x1234_ABCD -> mem_req_addr 0x8000_0000, wstrb 4'b1100, mem_req_wdata 0xABCD_ABCD, rsp_rdata 0.
- LW @0x8000_0002 -> rsp_valid at T+1, rsp_err=1, rsp_rdata 0, mem_req_valid never asserted. With XLEN=32, funct3=011 -> rsp_err=1.
- Backpressure: mem_req_ready low for 3 cycles and rsp_ready low for 2 cycles -> mem_req_* and rsp_* stay stable, exactly one bus handshake, req_ready=0 throughout.
- mem_rsp_err=1 on a LW -> rsp_err=1, rsp_rdata 0. XLEN=64: LW @0x...4, rdata 0x8000_0001_0000_0000 -> 0xFFFF_FFFF_8000_0001; LWU -> 0x0000_0000_8000_0001.
- rst asserted in WAIT -> next cycle IDLE with all outputs at reset values. A late mem_rsp_valid is ignored. The following LW completes normally.
